// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - size encodings, FSM state constants and load/error helpers
package dmem_pkg;

  localparam int DMEM_DEPTH_WORDS = 256;
  localparam int DMEM_ADDR_W      = 10;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  // beyond: some address bit above the decoded range is set
  function automatic logic access_error(input logic we, input logic [2:0] size,
                                        input logic [1:0] off, input logic beyond);
    logic e;
    case (size)
      SIZE_B:  e = 1'b0;
      SIZE_BU: e = we;
      SIZE_H:  e = off[0];
      SIZE_HU: e = off[0] | we;
      SIZE_W:  e = |off;
      default: e = 1'b1;
    endcase
    return e | beyond;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (size)
      SIZE_B:  r = {{24{sh[7]}}, sh[7:0]};
      SIZE_BU: r = {24'h0, sh[7:0]};
      SIZE_H:  r = {{16{sh[15]}}, sh[15:0]};
      SIZE_HU: r = {16'h0, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - four byte-wide banks, per-lane write enable, registered word read
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] bank [DEPTH_WORDS];
    logic [7:0] q;

    // contents deliberately carry no reset so they survive a controller reset
    always_ff @(posedge clk) begin
      if (wr_be[i]) bank[wr_addr] <= wr_data[8*i +: 8];
      if (rd_en)    q             <= bank[rd_addr];
    end

    assign rd_data[8*i +: 8] = q;
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - three-state load/store responder: capture, access, respond
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int ADDR_W      = DMEM_ADDR_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int WORD_AW = ADDR_W - 2;

  state_t      state;
  logic        cap_we;
  logic [2:0]  cap_size;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic        accept;
  logic        access_err;
  logic [31:0] rd_word;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  assign req_ready  = rst && (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);
  assign accept     = req_valid && req_ready;
  assign access_err = access_error(cap_we, cap_size, cap_addr[1:0], |(cap_addr >> ADDR_W));

  // the read is launched at the accept edge so the word is ready during ACCESS
  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (WORD_AW)
  ) u_ram (
    .clk    (clk),
    .rd_en  (accept),
    .rd_addr(req_addr[ADDR_W-1:2]),
    .rd_data(rd_word),
    .wr_be  (wr_be),
    .wr_addr(cap_addr[ADDR_W-1:2]),
    .wr_data(wr_data)
  );

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = {4{cap_wdata[7:0]}};
    case (cap_size)
      SIZE_B: wr_be = 4'b0001 << cap_addr[1:0];
      SIZE_H: begin
        wr_be   = cap_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{cap_wdata[15:0]}};
      end
      SIZE_W: begin
        wr_be   = 4'b1111;
        wr_data = cap_wdata;
      end
      default: wr_be = 4'b0000;
    endcase
    // state is cleared asynchronously, so a reset in ACCESS suppresses the commit
    if (!(state == ST_ACCESS && cap_we && !access_err)) wr_be = 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cap_we    <= 1'b0;
      cap_size  <= SIZE_B;
      cap_addr  <= 32'h0;
      cap_wdata <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_we    <= req_we;
            cap_size  <= req_size;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rsp_err   <= access_err;
          rsp_rdata <= (access_err || cap_we) ? 32'h0
                                              : load_extend(cap_size, cap_addr[1:0], rd_word);
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
